lcd_rgb_drv: RTL and testbench

RGB-interface LCD timing generator and pixel driver. It is the output side of the panel RGB bus whose strap pins are sampled at power-up to produce `lcd_id`. After a valid `lcd_id` arrives, it takes ownership of the bus, drives HS/VS/DE and 16-bit RGB565 data, and requests pixels from the upstream frame source. It sits between the LCD ID reader and the top-level tri-state buffer on `lcd_rgb`.

---
 rtl/lcd_rgb_drv.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_rgb_drv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_drv.sv
// lcd_rgb_drv
// RGB-interface LCD timing generator and pixel driver. Waits for a known panel
// ID, latches that panel's timing set, then drives HS/VS/DE and RGB565 data
// while requesting pixels from the upstream frame source.
//
// Optional feature: define LCD_TEST_PATTERN_EN to replace i_pixel_data with
// eight vertical colour bars generated internally.
//
// Ports
//   i_clk          pixel clock (only clock)
//   i_rst          synchronous active-high reset
//   i_lcd_id       panel ID from the ID reader (16'h0000 = unknown)
//   i_pixel_data   RGB565 pixel, returned one cycle after o_data_req
//   o_data_req     pixel request, qualified with o_pixel_xpos/o_pixel_ypos
//   o_pixel_xpos   requested column
//   o_pixel_ypos   requested row
//   o_h_disp       active width of the latched mode (0 until running)
//   o_v_disp       active height of the latched mode (0 until running)
//   o_lcd_hs       horizontal sync, active low
//   o_lcd_vs       vertical sync, active low
//   o_lcd_de       data enable
//   o_lcd_bl       backlight enable
//   o_lcd_rgb_o    RGB data to the pad
//   o_lcd_rgb_oe   pad output enable (0 leaves strap pins as inputs)
//
// state | meaning
// IDLE  | bus released, counters held, waiting for a known lcd_id
// LOAD  | one cycle: latch the timing set of the selected panel
// RUN   | bus owned, timing generator free-running until reset
module lcd_rgb_drv #(
    parameter int H_DISP_MAX = 800,
    parameter int V_DISP_MAX = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_lcd_id,
    input  logic [15:0] i_pixel_data,
    output logic        o_data_req,
    output logic [10:0] o_pixel_xpos,
    output logic [10:0] o_pixel_ypos,
    output logic [10:0] o_h_disp,
    output logic [10:0] o_v_disp,
    output logic        o_lcd_hs,
    output logic        o_lcd_vs,
    output logic        o_lcd_de,
    output logic        o_lcd_bl,
    output logic [15:0] o_lcd_rgb_o,
    output logic        o_lcd_rgb_oe
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic        w_load;
    logic        w_id_ok;
    logic        w_run;
    logic        r_mode_800;
    logic [10:0] r_h_sync, r_h_back, r_h_disp, r_h_total;
    logic [10:0] r_v_sync, r_v_back, r_v_disp, r_v_total;
    logic [10:0] w_h_disp_sel, w_v_disp_sel;
    logic [10:0] r_h_cnt, r_v_cnt;
    logic [10:0] w_hs_start, w_vs_start;
    logic        w_req, w_hs_raw, w_vs_raw;
    logic [1:0]  r_hs_d, r_vs_d, r_de_d;
    logic [15:0] r_rgb;
    logic [15:0] w_src;

    assign w_id_ok = (i_lcd_id == 16'h4342) || (i_lcd_id == 16'h4384);
    assign w_run   = (r_state == S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (w_id_ok) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN:  w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mode_800 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Panel choice is frozen when leaving IDLE; later ID changes are ignored.
            if (r_state == S_IDLE && w_id_ok)
                r_mode_800 <= (i_lcd_id == 16'h4384);
        end
    end

    // Active size is clamped to the configured maximum; the total stays fixed,
    // so any clamped columns/rows become extra front porch.
    assign w_h_disp_sel = r_mode_800 ? 11'd800 : 11'd480;
    assign w_v_disp_sel = r_mode_800 ? 11'd480 : 11'd272;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_sync  <= '0; r_h_back <= '0; r_h_disp <= '0; r_h_total <= '0;
            r_v_sync  <= '0; r_v_back <= '0; r_v_disp <= '0; r_v_total <= '0;
        end else if (w_load) begin
            r_h_sync  <= r_mode_800 ? 11'd128  : 11'd41;
            r_h_back  <= r_mode_800 ? 11'd88   : 11'd2;
            r_h_total <= r_mode_800 ? 11'd1056 : 11'd525;
            r_v_sync  <= r_mode_800 ? 11'd2    : 11'd10;
            r_v_back  <= r_mode_800 ? 11'd33   : 11'd2;
            r_v_total <= r_mode_800 ? 11'd525  : 11'd286;
            r_h_disp  <= (w_h_disp_sel > 11'(H_DISP_MAX)) ? 11'(H_DISP_MAX) : w_h_disp_sel;
            r_v_disp  <= (w_v_disp_sel > 11'(V_DISP_MAX)) ? 11'(V_DISP_MAX) : w_v_disp_sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == r_h_total - 11'd1) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == r_v_total - 11'd1) ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_hs_start = r_h_sync + r_h_back;
    assign w_vs_start = r_v_sync + r_v_back;
    assign w_req      = w_run
                        && (r_h_cnt >= w_hs_start) && (r_h_cnt < w_hs_start + r_h_disp)
                        && (r_v_cnt >= w_vs_start) && (r_v_cnt < w_vs_start + r_v_disp);
    assign w_hs_raw   = !(w_run && (r_h_cnt < r_h_sync));
    assign w_vs_raw   = !(w_run && (r_v_cnt < r_v_sync));

    assign o_data_req   = w_req;
    assign o_pixel_xpos = w_req ? (r_h_cnt - w_hs_start) : 11'd0;
    assign o_pixel_ypos = w_req ? (r_v_cnt - w_vs_start) : 11'd0;

`ifdef LCD_TEST_PATTERN_EN
    logic [10:0] r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic [15:0] r_pat_d1;
    logic [15:0] w_bar_color;
    logic [10:0] w_bar_w;
    logic        w_unused_pix;

    assign w_unused_pix = ^i_pixel_data;
    assign w_bar_w      = r_h_disp >> 3;

    always_comb begin
        w_bar_color = 16'h0000;
        case (r_bar_idx)
            3'd0: w_bar_color = 16'hFFFF;
            3'd1: w_bar_color = 16'hFFE0;
            3'd2: w_bar_color = 16'h07FF;
            3'd3: w_bar_color = 16'h07E0;
            3'd4: w_bar_color = 16'hF81F;
            3'd5: w_bar_color = 16'hF800;
            3'd6: w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
    end

    // Bar column timer reloads during blanking so every line starts on bar 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_pat_d1  <= '0;
        end else begin
            r_pat_d1 <= w_req ? w_bar_color : 16'h0000;
            if (!w_req) begin
                r_bar_cnt <= w_bar_w - 11'd1;
                r_bar_idx <= '0;
            end else if (r_bar_cnt == 11'd0) begin
                r_bar_cnt <= w_bar_w - 11'd1;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt - 11'd1;
            end
        end
    end

    assign w_src = r_pat_d1;
`else
    assign w_src = i_pixel_data;
`endif

    // Sync and DE share the two-stage delay so pin spacing matches the table.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hs_d <= 2'b11;
            r_vs_d <= 2'b11;
            r_de_d <= 2'b00;
            r_rgb  <= '0;
        end else begin
            r_hs_d <= {r_hs_d[0], w_hs_raw};
            r_vs_d <= {r_vs_d[0], w_vs_raw};
            r_de_d <= {r_de_d[0], w_req};
            r_rgb  <= r_de_d[0] ? w_src : 16'h0000;
        end
    end

    assign o_lcd_hs     = r_hs_d[1];
    assign o_lcd_vs     = r_vs_d[1];
    assign o_lcd_de     = r_de_d[1];
    assign o_lcd_rgb_o  = r_rgb;
    assign o_lcd_bl     = w_run;
    assign o_lcd_rgb_oe = w_run;
    assign o_h_disp     = r_h_disp;
    assign o_v_disp     = r_v_disp;

endmodule

// File: tb/tb_lcd_rgb_drv.sv
module tb_lcd_rgb_drv;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_lcd_id;
    logic [15:0] i_pixel_data;
    logic        o_data_req;
    logic [10:0] o_pixel_xpos, o_pixel_ypos, o_h_disp, o_v_disp;
    logic        o_lcd_hs, o_lcd_vs, o_lcd_de, o_lcd_bl, o_lcd_rgb_oe;
    logic [15:0] o_lcd_rgb_o;

    always #5 i_clk = ~i_clk;

    lcd_rgb_drv dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_lcd_id     (i_lcd_id),
        .i_pixel_data (i_pixel_data),
        .o_data_req   (o_data_req),
        .o_pixel_xpos (o_pixel_xpos),
        .o_pixel_ypos (o_pixel_ypos),
        .o_h_disp     (o_h_disp),
        .o_v_disp     (o_v_disp),
        .o_lcd_hs     (o_lcd_hs),
        .o_lcd_vs     (o_lcd_vs),
        .o_lcd_de     (o_lcd_de),
        .o_lcd_bl     (o_lcd_bl),
        .o_lcd_rgb_o  (o_lcd_rgb_o),
        .o_lcd_rgb_oe (o_lcd_rgb_oe)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: phase 0 = idle, 1 = load, 2 = run; m_t = cycles into run.
    int m_phase = 0;
    int m_t     = 0;
    int m_hsync = 0, m_hback = 0, m_hd = 0, m_ht = 1;
    int m_vsync = 0, m_vback = 0, m_vd = 0, m_vt = 1;

    logic        prev_req = 1'b0;
    logic [10:0] prev_x = '0, prev_y = '0;
    int          last_hs_cyc = 0;
    bit          gap_done = 1'b1;
    logic        de_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic void load_mode(input logic [15:0] id);
        if (id == 16'h4384) begin
            m_hsync = 128; m_hback = 88; m_hd = 800; m_ht = 1056;
            m_vsync = 2;   m_vback = 33; m_vd = 480; m_vt = 525;
        end else begin
            m_hsync = 41;  m_hback = 2;  m_hd = 480; m_ht = 525;
            m_vsync = 10;  m_vback = 2;  m_vd = 272; m_vt = 286;
        end
    endfunction

    // Position of the raster at run-cycle t, derived with plain division.
    function automatic void pos_at(input int t, output logic req, output int x, output int y,
                                   output logic hs, output logic vs);
        int col, line;
        col  = t % m_ht;
        line = (t / m_ht) % m_vt;
        req  = (col >= m_hsync + m_hback) && (col < m_hsync + m_hback + m_hd)
            && (line >= m_vsync + m_vback) && (line < m_vsync + m_vback + m_vd);
        x  = req ? col - (m_hsync + m_hback) : 0;
        y  = req ? line - (m_vsync + m_vback) : 0;
        hs = !(col < m_hsync);
        vs = !(line < m_vsync);
    endfunction

    function automatic logic [15:0] pix_of(input int x, input int y);
        logic [15:0] v;
`ifdef LCD_TEST_PATTERN_EN
        case (x / (m_hd / 8))
            0: v = 16'hFFFF;
            1: v = 16'hFFE0;
            2: v = 16'h07FF;
            3: v = 16'h07E0;
            4: v = 16'hF81F;
            5: v = 16'hF800;
            6: v = 16'h001F;
            default: v = 16'h0000;
        endcase
        if (y < 0) v = 16'h0000;
`else
        logic [4:0]  ylo;
        logic [10:0] xlo;
        ylo = 5'(y);
        xlo = 11'(x);
        v = {ylo, xlo};
`endif
        return v;
    endfunction

    task automatic step();
        logic        e_req, e_hs, e_vs, e_de, e_on, r2, dhs, dvs;
        int          e_x, e_y, x2, y2;
        logic [15:0] e_rgb;
        logic [10:0] e_hd, e_vd;
        @(posedge i_clk);
        cyc++;
        if (i_rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (i_lcd_id == 16'h4342 || i_lcd_id == 16'h4384) begin
                    m_phase = 1;
                    load_mode(i_lcd_id);
                end
                1: begin
                    m_phase  = 2;
                    m_t      = 0;
                    gap_done = 1'b0;
                end
                default: m_t++;
            endcase
        end
        #1;
        i_pixel_data = prev_req ? {prev_y[4:0], prev_x} : 16'($urandom);
        @(negedge i_clk);
        e_req = 1'b0; e_x = 0; e_y = 0; e_hs = 1'b1; e_vs = 1'b1;
        e_de = 1'b0; e_rgb = 16'h0000; e_on = 1'b0; e_hd = '0; e_vd = '0;
        if (m_phase == 2) begin
            e_on = 1'b1;
            e_hd = 11'(m_hd);
            e_vd = 11'(m_vd);
            pos_at(m_t, e_req, e_x, e_y, dhs, dvs);
            if (m_t >= 2) begin
                pos_at(m_t - 2, r2, x2, y2, e_hs, e_vs);
                e_de  = r2;
                e_rgb = r2 ? pix_of(x2, y2) : 16'h0000;
            end
        end
        check_eq("ctl", 64'({o_data_req, o_pixel_xpos, o_pixel_ypos, o_lcd_hs, o_lcd_vs,
                             o_lcd_de, o_lcd_bl, o_lcd_rgb_oe}),
                        64'({e_req, 11'(e_x), 11'(e_y), e_hs, e_vs, e_de, e_on, e_on}));
        check_eq("rgb", 64'(o_lcd_rgb_o), 64'(e_rgb));
        check_eq("disp", 64'({o_h_disp, o_v_disp}), 64'({e_hd, e_vd}));
        if (!o_lcd_hs) last_hs_cyc = cyc;
        if (m_phase == 2 && !gap_done && o_lcd_de && !de_prev) begin
            check_eq("de_gap", 64'(cyc - last_hs_cyc - 1), 64'(m_hback));
            gap_done = 1'b1;
        end
        de_prev  = o_lcd_de;
        prev_req = o_data_req;
        prev_x   = o_pixel_xpos;
        prev_y   = o_pixel_ypos;
    endtask

    initial begin
        logic [15:0] junk;
        i_rst        = 1'b1;
        i_lcd_id     = 16'h0000;
        i_pixel_data = 16'h0000;
        repeat (3) step();
        i_rst = 1'b0;
        repeat (10000) step();
        repeat (200) begin
            do junk = 16'($urandom); while (junk == 16'h4342 || junk == 16'h4384);
            i_lcd_id = junk;
            step();
        end
        i_lcd_id = 16'h4342;
        repeat (20 * 525 + $urandom_range(0, 300)) step();
        i_lcd_id = 16'h4384;
        repeat ($urandom_range(300, 800)) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        repeat (38 * 1056) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
